fifo_wr_arbiter: RTL

Round-robin write-side arbiter that shares one synchronous FIFO (FIFO_WIDTH-bit, FIFO_DEPTH-deep, registered flags and registered wr_ack/overflow) among NUM_REQ producers in the SPI environment. It sits between the producers and the FIFO write port, grants at most one write per cycle, and throttles on full/almostfull so the FIFO never overflows in normal operation. It routes the FIFO's write acknowledge or overflow back to the requester that issued the write, and counts overflow events.

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/rr_picker.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared defaults and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_CNT_WIDTH  = 8;
    localparam int ID_W           = $clog2(DEF_NUM_REQ);

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
        return (val >= max) ? max : val + 32'd1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotate-priority picker: first set bit of i_elig after i_last, wrapping.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_elig,
    input  logic [IW-1:0] i_last,
    output logic          o_vld,
    output logic [IW-1:0] o_win
);

    // Outer loop walks priority order, inner loop keeps every bit-select constant.
    always_comb begin
        o_vld = 1'b0;
        o_win = '0;
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!o_vld && i_elig[j] && (j == ((int'(i_last) + k) % N))) begin
                    o_vld = 1'b1;
                    o_win = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with full/almostfull throttling and ack/overflow routing back to the writer.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic [NUM_REQ-1:0]            o_ack,
    output logic [NUM_REQ-1:0]            o_nack,
    output logic [FIFO_WIDTH-1:0]         o_fifo_data_in,
    output logic                          o_fifo_wr_en,
    input  logic                          i_fifo_wr_ack,
    input  logic                          i_fifo_overflow,
    input  logic                          i_fifo_full,
    input  logic                          i_fifo_almostfull,
    output logic [CNT_WIDTH-1:0]          o_ovf_cnt
);

    localparam int          IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_WIDTH) - 64'd1);

    logic [NUM_REQ-1:0]    r_gnt;
    logic [NUM_REQ-1:0]    r_ack;
    logic [NUM_REQ-1:0]    r_nack;
    logic [FIFO_WIDTH-1:0] r_data;
    logic                  r_wr_en;
    logic [IW-1:0]         r_last;
    logic                  r_pend_vld;
    logic [IW-1:0]         r_pend_id;
    logic [CNT_WIDTH-1:0]  r_ovf_cnt;

    logic [NUM_REQ-1:0]    w_elig;
    logic                  w_pick_vld;
    logic [IW-1:0]         w_win;
    logic                  w_allow;
    logic [FIFO_WIDTH-1:0] w_sel_data;

    // A held request is masked in its grant cycle so it cannot win twice.
    assign w_elig  = i_req & ~r_gnt;
    // Flags are registered, so one write may already be in flight toward almostfull.
    assign w_allow = w_pick_vld && !i_fifo_full && !(r_wr_en && i_fifo_almostfull);

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .i_elig (w_elig),
        .i_last (r_last),
        .o_vld  (w_pick_vld),
        .o_win  (w_win)
    );

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == IW'(i)) begin
                w_sel_data = i_req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    // r_last names the write on the bus while r_wr_en is high; its response
    // arrives one cycle later, hence the pend stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt      <= '0;
            r_ack      <= '0;
            r_nack     <= '0;
            r_data     <= '0;
            r_wr_en    <= 1'b0;
            r_last     <= IW'(NUM_REQ - 1);
            r_pend_vld <= 1'b0;
            r_pend_id  <= '0;
            r_ovf_cnt  <= '0;
        end else begin
            r_gnt      <= '0;
            r_ack      <= '0;
            r_nack     <= '0;
            r_wr_en    <= w_allow;
            r_pend_vld <= r_wr_en;
            r_pend_id  <= r_last;
            if (w_allow) begin
                r_gnt[w_win] <= 1'b1;
                r_data       <= w_sel_data;
                r_last       <= w_win;
            end
            if (r_pend_vld && i_fifo_wr_ack) begin
                r_ack[r_pend_id] <= 1'b1;
            end
            if (r_pend_vld && i_fifo_overflow) begin
                r_nack[r_pend_id] <= 1'b1;
            end
            if (i_fifo_overflow) begin
                r_ovf_cnt <= CNT_WIDTH'(sat_inc(32'(r_ovf_cnt), CNT_MAX));
            end
        end
    end

    assign o_gnt          = r_gnt;
    assign o_ack          = r_ack;
    assign o_nack         = r_nack;
    assign o_fifo_data_in = r_data;
    assign o_fifo_wr_en   = r_wr_en;
    assign o_ovf_cnt      = r_ovf_cnt;

    a_gnt_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (FIFO_DEPTH >= 2) && $onehot0(r_gnt));

endmodule
